dt_time_manager: RTL and testbench
==================================

DT_TIME_MANAGER -- requirements
Module: dt_time_manager

Interface
REQ-001 Parameter N_REQ, default 4: number of timestep-request sources, range 1..16.
REQ-002 Parameter DT_WIDTH, default 32: width of dt values, matching dt_t.
REQ-003 Parameter TIME_WIDTH, default 64: width of the emulated-time accumulator.
REQ-004 Parameter DT_MAX, default 32'h0000_FFFF: largest dt ever issued.
REQ-005 Port clk  input  1: the single emulator clock (emu_if clk).
REQ-006 Port rst  input  1: asynchronous, active-high reset (emu_if rst).
REQ-007 Port dt_req  input  N_REQ x DT_WIDTH: per-source requested timestep.
REQ-008 Port req_en  input  N_REQ: request i participates when high.
REQ-009 Port start  input  1: single-cycle pulse, IDLE/PAUSED -> RUN.
REQ-010 Port pause  input  1: single-cycle pulse, RUN -> PAUSED.
REQ-011 Port clr_time  input  1: single-cycle pulse that zeroes emu_time and returns to IDLE.
REQ-012 Port stop_time  input  TIME_WIDTH: emulated-time limit; 0 disables the limit.
REQ-013 Port dt  output  DT_WIDTH: issued timestep, drives emu_if dt.
REQ-014 Port emu_time  output  TIME_WIDTH: accumulated emulated time.
REQ-015 Port running  output  1: high in RUN.
REQ-016 Port done  output  1: high in DONE.

Function
REQ-017 dt_min = minimum of dt_req[i] over i with req_en[i]=1; disabled entries count as DT_MAX; result clamped to DT_MAX.
REQ-018 States: IDLE, RUN, PAUSED, DONE; dt is 0 in every state except RUN.
REQ-019 In RUN, dt is registered: requests sampled at edge k appear on dt after edge k+1 (1-cycle latency).
REQ-020 On every edge while dt output is nonzero, emu_time <= emu_time + dt.
REQ-021 If stop_time != 0 and emu_time + dt_min >= stop_time, issued dt = stop_time - emu_time, and the FSM enters DONE on the same edge.
REQ-022 Time addition saturates at all-ones TIME_WIDTH; on saturation, the FSM enters DONE.
REQ-023 Transitions: IDLE-start->RUN; RUN-pause->PAUSED; PAUSED-start->RUN; any state-clr_time->IDLE; DONE is left only via clr_time.
REQ-024 Priority on simultaneous pulses: clr_time > pause > start.
REQ-025 dt_min = 0 in RUN is legal: dt = 0, time holds, and the FSM stays in RUN.
REQ-026 All req_en low in RUN: dt = DT_MAX.
REQ-027 Changing stop_time mid-run takes effect at the next edge; if it is already <= emu_time, dt = 0 and the FSM enters DONE.

Reset
REQ-028 rst high asynchronously forces: state IDLE, dt 0, emu_time 0, running 0, done 0.
REQ-029 Reset mid-RUN discards the in-flight dt; the first post-reset dt is issued no earlier than 2 edges after start.

Structure
REQ-030 Shared package holds dt_t width, TIME_WIDTH, DT_MAX default, and the state enum.
REQ-031 Sub-module dt_min_tree is combinational (min over N_REQ with enable masking).
REQ-032 FSM, dt register, and time accumulator reside in dt_time_manager.

Verification
REQ-033 req_en=4'b0111, dt_req={9,5,7,3}, start -> after 2 edges, dt=5 and emu_time increments by 5 per cycle.
REQ-034 stop_time=12, all dt_req=5 with req_en=4'b0001, start -> dt sequence 5,5,2, then 0; emu_time=12; done=1.
REQ-035 RUN at emu_time=20, pause and start asserted in the same cycle -> PAUSED, dt=0, emu_time holds 20.
REQ-036 req_en=0 in RUN -> dt=16'hFFFF; emu_time=2^64-2 with dt=16'hFFFF -> emu_time saturates at all-ones, done=1.
REQ-037 rst pulsed mid-RUN at emu_time=100 -> emu_time=0 and dt=0 immediately (asynchronously); after start, the first nonzero dt appears on the second edge.
REQ-038 In DONE, start -> no change; clr_time -> IDLE with emu_time=0.

Source files
------------

// File: rtl/dt_time_manager_pkg.sv
// Shared types and defaults for the emulator timestep manager and its helpers.
package dt_time_manager_pkg;

    localparam int DT_W   = 32;
    localparam int TIME_W = 64;

    localparam logic [DT_W-1:0] DT_MAX_DEFAULT = 32'h0000_FFFF;

    typedef logic [DT_W-1:0]   dt_t;
    typedef logic [TIME_W-1:0] emu_time_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } tm_state_e;

endpackage

// File: rtl/dt_time_manager_min_tree.sv
// Combinational balanced min-tree over the enabled timestep requests.
// Disabled or oversized requests enter the tree as DT_MAX, so the result is already clamped.
module dt_min_tree
    import dt_time_manager_pkg::*;
#(
    parameter int                  N_REQ    = 4,
    parameter int                  DT_WIDTH = DT_W,
    parameter logic [DT_WIDTH-1:0] DT_MAX   = DT_WIDTH'(DT_MAX_DEFAULT)
) (
    input  logic [N_REQ-1:0][DT_WIDTH-1:0] dt_req,
    input  logic [N_REQ-1:0]               req_en,
    output logic [DT_WIDTH-1:0]            dt_min
);

    localparam int LEVELS = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LEAVES = 1 << LEVELS;

    logic [LEAVES-1:0][DT_WIDTH-1:0] node;

    // NOTE: combinational logic uses blocking '=' so each tree level sees the
    // level below it within the same evaluation; every node is written before use.
    always_comb begin
        node = '0;
        for (int i = 0; i < N_REQ; i++) begin
            node[i] = (req_en[i] && (dt_req[i] < DT_MAX)) ? dt_req[i] : DT_MAX;
        end
        for (int i = N_REQ; i < LEAVES; i++) begin
            node[i] = DT_MAX;
        end
        // In-place reduction: slot j of a level only overwrites slots already consumed.
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int j = 0; j < (LEAVES >> (lvl + 1)); j++) begin
                node[j] = (node[2*j] < node[2*j+1]) ? node[2*j] : node[2*j+1];
            end
        end
        dt_min = node[0];
    end

endmodule

// File: rtl/dt_time_manager.sv
// Emulator timestep manager: picks the smallest requested dt, issues it one cycle later
// while running, and accumulates emulated time with a stop limit and saturation.
module dt_time_manager
    import dt_time_manager_pkg::*;
#(
    parameter int                  N_REQ      = 4,
    parameter int                  DT_WIDTH   = DT_W,
    parameter int                  TIME_WIDTH = TIME_W,
    parameter logic [DT_WIDTH-1:0] DT_MAX     = DT_WIDTH'(DT_MAX_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0][DT_WIDTH-1:0] dt_req,
    input  logic [N_REQ-1:0]               req_en,
    input  logic                           start,
    input  logic                           pause,
    input  logic                           clr_time,
    input  logic [TIME_WIDTH-1:0]          stop_time,
    output logic [DT_WIDTH-1:0]            dt,
    output logic [TIME_WIDTH-1:0]          emu_time,
    output logic                           running,
    output logic                           done
);

    tm_state_e               state_q, state_d;
    logic [DT_WIDTH-1:0]     dt_q, dt_d;
    logic [TIME_WIDTH-1:0]   time_q, time_d;

    logic [DT_WIDTH-1:0]     dt_min;
    logic [TIME_WIDTH:0]     sum_ext;
    logic [TIME_WIDTH:0]     proj_ext;
    logic [TIME_WIDTH-1:0]   time_next;
    logic [DT_WIDTH-1:0]     dt_issue;
    logic                    saturated;
    logic                    limit_on;
    logic                    limit_hit;
    logic                    limit_near;

    dt_min_tree #(
        .N_REQ    (N_REQ),
        .DT_WIDTH (DT_WIDTH),
        .DT_MAX   (DT_MAX)
    ) u_min_tree (
        .dt_req (dt_req),
        .req_en (req_en),
        .dt_min (dt_min)
    );

    // Time after the dt currently on the output has been consumed, and the
    // dt that would follow it if the run continues.
    always_comb begin
        sum_ext    = {1'b0, time_q} + (TIME_WIDTH+1)'(dt_q);
        saturated  = sum_ext[TIME_WIDTH] | (&sum_ext[TIME_WIDTH-1:0]);
        time_next  = sum_ext[TIME_WIDTH] ? '1 : sum_ext[TIME_WIDTH-1:0];
        limit_on   = |stop_time;
        limit_hit  = limit_on && (time_next >= stop_time);
        proj_ext   = {1'b0, time_next} + (TIME_WIDTH+1)'(dt_min);
        limit_near = limit_on && (proj_ext >= {1'b0, stop_time});
        dt_issue   = limit_near ? DT_WIDTH'(stop_time - time_next) : dt_min;
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        dt_d    = '0;
        time_d  = time_q;

        if (clr_time) begin
            state_d = ST_IDLE;
            time_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    if (start && !pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    time_d = time_next;
                    // The trimmed final dt lands on this edge, so DONE is entered
                    // exactly when the accumulated time reaches the limit.
                    if (limit_hit || saturated) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        dt_d = dt_issue;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: asynchronous reset with non-blocking '<=' for all state; the
    // in-flight dt is dropped so a restart always begins from a clean pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dt_q    <= '0;
            time_q  <= '0;
        end else begin
            state_q <= state_d;
            dt_q    <= dt_d;
            time_q  <= time_d;
        end
    end

    assign dt       = dt_q;
    assign emu_time = time_q;
    assign running  = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_dt_time_manager.sv
// Scoreboard bench: two instances (64-bit and 17-bit time) share stimulus; a behavioural
// model predicts each post-edge state and a monitor pops and compares every cycle.
module tb_dt_time_manager;

    localparam int              NR    = 4;
    localparam longint unsigned MAX_A = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam longint unsigned MAX_B = 64'h0000_0000_0001_FFFF;
    localparam longint unsigned DTMAX = 64'h0000_0000_0000_FFFF;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NR-1:0][31:0]   dt_req = '0;
    logic [NR-1:0]         req_en = '0;
    logic                  start = 1'b0;
    logic                  pause = 1'b0;
    logic                  clr_time = 1'b0;
    logic [63:0]           stop_time = '0;

    logic [31:0] dt_a, dt_b;
    logic [63:0] emu_a;
    logic [16:0] emu_b;
    logic        running_a, done_a, running_b, done_b;

    always #5 clk = ~clk;

    dt_time_manager dut_a (
        .clk(clk), .rst(rst), .dt_req(dt_req), .req_en(req_en),
        .start(start), .pause(pause), .clr_time(clr_time), .stop_time(stop_time),
        .dt(dt_a), .emu_time(emu_a), .running(running_a), .done(done_a)
    );

    dt_time_manager #(.TIME_WIDTH(17)) dut_b (
        .clk(clk), .rst(rst), .dt_req(dt_req), .req_en(req_en),
        .start(start), .pause(pause), .clr_time(clr_time), .stop_time(stop_time[16:0]),
        .dt(dt_b), .emu_time(emu_b), .running(running_b), .done(done_b)
    );

    typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} m_state_e;
    typedef struct {
        m_state_e        st;
        longint unsigned t;
        longint unsigned dt;
    } mdl_t;
    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    exp_t sb_q[$];
    mdl_t m_a, m_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Smallest enabled request, disabled entries and large values count as DT_MAX.
    function automatic longint unsigned req_min();
        longint unsigned d = DTMAX;
        for (int i = 0; i < NR; i++) begin
            if (req_en[i] && longint'(dt_req[i]) < d) d = longint'(dt_req[i]);
        end
        return d;
    endfunction

    // State after one clock edge, given the inputs currently driven.
    function automatic mdl_t step(input mdl_t m, input longint unsigned maxv,
                                  input longint unsigned stop);
        mdl_t r;
        longint unsigned s;
        longint unsigned d;
        r = m;
        if (rst) begin
            r.st = M_IDLE; r.t = 0; r.dt = 0;
        end else if (clr_time) begin
            r.st = M_IDLE; r.t = 0; r.dt = 0;
        end else if (r.st == M_IDLE || r.st == M_PAUSED) begin
            if (start && !pause) r.st = M_RUN;
        end else if (r.st == M_RUN) begin
            s = r.t + r.dt;
            if (s < r.t || s > maxv) s = maxv;
            r.t = s;
            if (s == maxv || (stop != 0 && s >= stop)) begin
                r.st = M_DONE; r.dt = 0;
            end else if (pause) begin
                r.st = M_PAUSED; r.dt = 0;
            end else begin
                d = req_min();
                r.dt = (stop != 0 && s + d >= stop) ? stop - s : d;
            end
        end
        return r;
    endfunction

    // Drive one cycle of inputs at the falling edge, predict, then wait for the next falling edge.
    task automatic tick(input bit s, input bit p, input bit c, input bit r);
        exp_t e;
        start = s; pause = p; clr_time = c; rst = r;
        if (r) begin
            #1;
            check("async_rst_dt_a",   dt_a, 0);
            check("async_rst_time_a", emu_a, 0);
            check("async_rst_flags_a", {running_a, done_a}, 0);
            check("async_rst_time_b", emu_b, 0);
        end
        m_a = step(m_a, MAX_A, stop_time);
        m_b = step(m_b, MAX_B, stop_time & MAX_B);
        e.a = m_a;
        e.b = m_b;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_a_dt",      dt_a,      e.a.dt);
                check("sb_a_time",    emu_a,     e.a.t);
                check("sb_a_running", running_a, e.a.st == M_RUN);
                check("sb_a_done",    done_a,    e.a.st == M_DONE);
                check("sb_b_dt",      dt_b,      e.b.dt);
                check("sb_b_time",    emu_b,     e.b.t);
                check("sb_b_running", running_b, e.b.st == M_RUN);
                check("sb_b_done",    done_b,    e.b.st == M_DONE);
            end
        end
    end

    initial begin : driver
        int exp_seq [5];
        m_a = '{M_IDLE, 0, 0};
        m_b = '{M_IDLE, 0, 0};
        @(negedge clk);

        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        check("reset_dt",    dt_a, 0);
        check("reset_time",  emu_a, 0);
        check("reset_flags", {running_a, done_a}, 0);

        // Minimum over enabled sources with one-cycle issue latency.
        dt_req[0] = 9; dt_req[1] = 5; dt_req[2] = 7; dt_req[3] = 3;
        req_en = 4'b0111; stop_time = 0;
        tick(1, 0, 0, 0);
        check("min_edge1_dt", dt_a, 0);
        check("min_edge1_running", running_a, 1);
        tick(0, 0, 0, 0);
        check("min_edge2_dt", dt_a, 5);
        for (int k = 1; k <= 3; k++) begin
            tick(0, 0, 0, 0);
            check("min_time_step", emu_a, 64'(5 * k));
        end

        // pause beats start; the last issued dt is consumed, then time holds.
        tick(1, 1, 0, 0);
        check("pause_time", emu_a, 20);
        check("pause_dt", dt_a, 0);
        check("pause_running", running_a, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        check("pause_hold", emu_a, 20);

        // Resume to 100, then asynchronous reset mid-run.
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        for (int k = 0; k < 16; k++) tick(0, 0, 0, 0);
        check("run_to_100", emu_a, 100);
        tick(0, 0, 0, 1);
        check("rst_mid_time", emu_a, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("restart_edge1_dt", dt_a, 0);
        tick(0, 0, 0, 0);
        check("restart_edge2_dt", dt_a, 5);

        // Stop limit trims the final dt.
        tick(0, 0, 1, 0);
        for (int i = 0; i < NR; i++) dt_req[i] = 5;
        req_en = 4'b0001; stop_time = 12;
        exp_seq = '{0, 5, 5, 2, 0};
        for (int k = 0; k < 5; k++) begin
            tick(k == 0, 0, 0, 0);
            check("stop_dt_seq", dt_a, 64'(exp_seq[k]));
        end
        check("stop_time_final", emu_a, 12);
        check("stop_done", done_a, 1);

        // DONE ignores start; only clr_time leaves.
        tick(1, 0, 0, 0);
        check("done_start_ignored", {running_a, done_a}, 2'b01);
        check("done_time_kept", emu_a, 12);
        tick(0, 0, 1, 0);
        check("clr_flags", {running_a, done_a}, 0);
        check("clr_time", emu_a, 0);

        // No enabled request gives DT_MAX; the narrow instance saturates.
        stop_time = 0; req_en = 4'b0000;
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        check("all_disabled_dt", dt_a, DTMAX);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        check("sat_b_pre_time", emu_b, 17'h1FFFE);
        check("sat_b_pre_dt", dt_b, DTMAX);
        tick(0, 0, 0, 0);
        check("sat_b_time", emu_b, 17'h1FFFF);
        check("sat_b_done", done_b, 1);
        check("sat_b_dt", dt_b, 0);
        check("sat_a_still_running", running_a, 1);

        // Lowering stop_time below the current time ends the run at the next edge.
        tick(0, 0, 1, 0);
        req_en = 4'b0001; dt_req[0] = 5;
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        stop_time = 8;
        tick(0, 0, 0, 0);
        check("late_stop_done", done_a, 1);
        check("late_stop_dt", dt_a, 0);
        check("late_stop_time", emu_a, 15);

        // A zero request keeps the run alive with time frozen.
        tick(0, 0, 1, 0);
        stop_time = 0; dt_req[0] = 0;
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        check("zero_dt", dt_a, 0);
        check("zero_time", emu_a, 0);
        check("zero_running", running_a, 1);

        // Randomized traffic against the model.
        tick(0, 0, 1, 0);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < NR; i++) begin
                    dt_req[i] = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 30));
                end
                req_en = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 24) == 0) begin
                stop_time = ($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom_range(50, 3000));
            end
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
        end

        tick(0, 0, 0, 0);
        @(posedge clk);
        #2;
        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
